// File: rtl/comparator_pkg.sv
// Shared flag codes and self-test FSM state encoding for the comparator slice.
package comparator_pkg;

    localparam logic [1:0] FLAG_EQ  = 2'b00;
    localparam logic [1:0] FLAG_LT  = 2'b01;
    localparam logic [1:0] FLAG_GT  = 2'b10;
    localparam logic [1:0] FLAG_BAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/comparator_ref.sv
// Reference comparator: produces the expected flag code for unsigned operands a and b.
module comparator_ref
    import comparator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       flag
);

    always_comb begin
        flag = FLAG_BAD;
        if (a == b) begin
            flag = FLAG_EQ;
        end else if (a < b) begin
            flag = FLAG_LT;
        end else begin
            flag = FLAG_GT;
        end
    end

endmodule

// File: rtl/comparator_selftest.sv
// Exhaustive self-test sequencer for an external comparator with LATENCY-cycle response.
// Optional build macro SELFTEST_STOP_ON_FAIL_EN ends a run at the first mismatch and holds the failing vector.
module comparator_selftest
    import comparator_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [1:0]       flag,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count
);

    localparam int         VEC_W     = 2 * WIDTH;
    localparam logic [3:0] WAIT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [3:0]         wait_q, wait_d;
    logic [15:0]        err_q, err_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [1:0]         exp_flag;
    logic               mismatch;

    comparator_ref #(
        .WIDTH(WIDTH)
    ) u_ref (
        .a    (vec_q[VEC_W-1:WIDTH]),
        .b    (vec_q[WIDTH-1:0]),
        .flag (exp_flag)
    );

    assign mismatch = (flag != exp_flag);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        err_d   = err_q;
        pass_d  = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (LATENCY > 1) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_LOAD;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (wait_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch && (err_q != 16'hFFFF)) begin
                    err_d = err_q + 16'd1;
                end
                // The last vector ends the run instead of wrapping the counter.
                if (vec_q == '1) begin
                    state_d = ST_FINISH;
                    vec_d   = '0;
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + VEC_W'(1);
                end
`ifdef SELFTEST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_d = ST_FINISH;
                    vec_d   = vec_q;
                end
`endif
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q == ST_CHECK) && (state_d == ST_FINISH)) begin
            pass_d = (err_d == 16'd0);
        end

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            wait_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign A         = vec_q[VEC_W-1:WIDTH];
    assign B         = vec_q[WIDTH-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_comparator_selftest.sv
// Scoreboard bench for comparator_selftest: randomised faulty comparator models at LATENCY 1 and 3.
// Expectations adapt when SELFTEST_STOP_ON_FAIL_EN is defined.
module tb_comparator_selftest;

    localparam int W  = 4;
    localparam int NV = 1 << (2 * W);
`ifdef SELFTEST_STOP_ON_FAIL_EN
    localparam int PROTECT = 60;
`else
    localparam int PROTECT = 0;
`endif

    typedef struct {
        int which;
        int done_cyc;
        int pass;
        int err;
        int a;
        int b;
    } exp_t;

    logic           clk    = 1'b0;
    logic           rst    = 1'b1;
    logic           start1 = 1'b0;
    logic           start3 = 1'b0;
    logic [W-1:0]   a1, b1, a3, b3;
    logic [1:0]     flag1 = '0, flag3 = '0, p1 = '0, p2 = '0;
    logic           busy1, done1, pass1, busy3, done3, pass3;
    logic [15:0]    err1, err3;

    int             cyc    = 0;
    int             checks = 0;
    int             errors = 0;
    exp_t           exp_q[$];

    bit             stuck = 1'b0;
    bit             fault_mask [NV];
    logic [1:0]     bad_code [NV];

    int             order_err1 = 0, order_err3 = 0;
    logic [2*W-1:0] last1 = '0, last3 = '0;
    logic           prev_busy1 = 1'b0, prev_busy3 = 1'b0;
    logic           prev_done1 = 1'b0, prev_done3 = 1'b0;

    comparator_selftest #(.WIDTH(W), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .flag(flag1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
    );

    comparator_selftest #(.WIDTH(W), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .flag(flag3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Correct unsigned comparison of the vector index {A,B}, A in the upper half.
    function automatic logic [1:0] true_code(int v);
        int a = v / (1 << W);
        int b = v % (1 << W);
        if (a == b) return 2'b00;
        if (a < b)  return 2'b01;
        return 2'b10;
    endfunction

    function automatic logic [1:0] model_flag(int v);
        if (stuck) return 2'b00;
        if (fault_mask[v]) return bad_code[v];
        return true_code(v);
    endfunction

    // Comparator models under test: one register deep for dut1, three deep for dut3.
    always @(posedge clk) begin
        flag1 <= model_flag(int'({a1, b1}));
        p1    <= model_flag(int'({a3, b3}));
        p2    <= p1;
        flag3 <= p2;
    end

    function automatic exp_t predict(int which, int start_cyc);
        exp_t e;
        int   lat   = (which == 3) ? 3 : 1;
        int   errs  = 0;
        int   first = -1;
        for (int v = 0; v < NV; v++) begin
            if (model_flag(v) != true_code(v)) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        if (errs > 65535) errs = 65535;
        e.which    = which;
        e.done_cyc = start_cyc + NV * (lat + 1);
        e.pass     = (errs == 0) ? 1 : 0;
        e.err      = errs;
        e.a        = 0;
        e.b        = 0;
`ifdef SELFTEST_STOP_ON_FAIL_EN
        if (first >= 0) begin
            e.err      = 1;
            e.done_cyc = start_cyc + (first + 1) * (lat + 1);
            e.a        = first / (1 << W);
            e.b        = first % (1 << W);
        end
`endif
        return e;
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic setupModel(bit is_stuck, int prob, int protect);
        stuck = is_stuck;
        for (int v = 0; v < NV; v++) begin
            fault_mask[v] = (v >= protect) && (int'($urandom_range(99)) < prob);
            bad_code[v]   = true_code(v) ^ 2'($urandom_range(3, 1));
        end
    endtask

    task automatic applyStimulus(int which, output int s);
        @(negedge clk);
        s = cyc + 1;
        exp_q.push_back(predict(which, s));
        if (which == 3) start3 = 1'b1;
        else            start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        checkOutput("busy_rise", (which == 3) ? int'(busy3) : int'(busy1), 1);
    endtask

    task automatic waitDone(int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic checkReset(string tag, logic [W-1:0] a, logic [W-1:0] b, logic busy,
                              logic done, logic pass, logic [15:0] err);
        checkOutput({tag, "_A"}, int'(a), 0);
        checkOutput({tag, "_B"}, int'(b), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_pass"}, int'(pass), 0);
        checkOutput({tag, "_err_count"}, int'(err), 0);
    endtask

    task automatic monitorDone(int which, logic busy, logic pass, logic [15:0] err,
                               logic [W-1:0] a, logic [W-1:0] b, logic prev_done, int order_err);
        exp_t e;
        checkOutput("done_one_cycle", int'(prev_done), 0);
        checkOutput("busy_low_at_done", int'(busy), 0);
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", which, 0);
            return;
        end
        e = exp_q.pop_front();
        checkOutput("done_dut", which, e.which);
        checkOutput("done_cycle", cyc, e.done_cyc);
        checkOutput("pass", int'(pass), e.pass);
        checkOutput("err_count", int'(err), e.err);
        checkOutput("final_A", int'(a), e.a);
        checkOutput("final_B", int'(b), e.b);
        checkOutput("vector_order", order_err, 0);
    endtask

    // Monitor: pops the scoreboard on every done pulse and tracks vector ordering.
    always @(negedge clk) begin
        if (!rst) begin
            if (done1) monitorDone(1, busy1, pass1, err1, a1, b1, prev_done1, order_err1);
            if (done3) monitorDone(3, busy3, pass3, err3, a3, b3, prev_done3, order_err3);
        end
        if (busy1 && !prev_busy1) begin
            order_err1 = ({a1, b1} != '0) ? 1 : 0;
            last1      = {a1, b1};
        end else if (busy1 && ({a1, b1} != last1)) begin
            if ({a1, b1} != 8'(last1 + 8'd1)) order_err1++;
            last1 = {a1, b1};
        end
        if (busy3 && !prev_busy3) begin
            order_err3 = ({a3, b3} != '0) ? 1 : 0;
            last3      = {a3, b3};
        end else if (busy3 && ({a3, b3} != last3)) begin
            if ({a3, b3} != 8'(last3 + 8'd1)) order_err3++;
            last3 = {a3, b3};
        end
        prev_busy1 = busy1;
        prev_busy3 = busy3;
        prev_done1 = done1;
        prev_done3 = done3;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        $display("[TB] comparator_selftest bench starting");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("rst1", a1, b1, busy1, done1, pass1, err1);
        checkReset("rst3", a3, b3, busy3, done3, pass3, err3);
        rst = 1'b0;

        setupModel(1'b0, 0, 0);
        applyStimulus(1, s);
        waitDone(3000);

        setupModel(1'b1, 0, 0);
        applyStimulus(1, s);
        waitDone(3000);

        setupModel(1'b0, 3, 0);
        applyStimulus(1, s);
        waitDone(3000);

        setupModel(1'b0, 1, 0);
        applyStimulus(1, s);
        waitDone(3000);

        setupModel(1'b0, 0, 0);
        applyStimulus(3, s);
        waitDone(5000);

        setupModel(1'b0, 2, 0);
        applyStimulus(3, s);
        waitDone(5000);

        // A second start mid-run must not restart the sequence or clear err_count.
        setupModel(1'b0, 4, PROTECT);
        applyStimulus(1, s);
        while (cyc < s + 50) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        waitDone(3000);

        // Reset mid-run, together with start, aborts silently.
        setupModel(1'b0, 6, PROTECT);
        if (PROTECT == 0) fault_mask[10] = 1'b1;
        applyStimulus(1, s);
        while (cyc < s + 100) @(negedge clk);
        rst    = 1'b1;
        start1 = 1'b1;
        @(negedge clk);
        checkReset("abort", a1, b1, busy1, done1, pass1, err1);
        exp_q.delete();
        rst    = 1'b0;
        start1 = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("abort_idle_busy", int'(busy1), 0);

        setupModel(1'b0, 0, 0);
        applyStimulus(1, s);
        waitDone(3000);
        repeat (3) @(negedge clk);
        checkOutput("pass_held", int'(pass1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/comparator_selftest.md
COMPARATOR_SELFTEST -- requirements
Module: comparator_selftest

Interface
REQ-001 Parameter WIDTH, default 4: operand width driven to the comparator under test.
REQ-002 Parameter LATENCY, default 1, legal range 1..15: cycles from driving A/B to a valid flag.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a test run when idle.
REQ-006 A  output  WIDTH  operand A driven to the comparator.
REQ-007 B  output  WIDTH  operand B driven to the comparator.
REQ-008 flag  input  2  comparator result: 2'b00 equal, 2'b01 A<B, 2'b10 A>B, 2'b11 illegal.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high for exactly one cycle at run completion.
REQ-011 pass  output  1  high when the last completed run had zero mismatches; held until the next start.
REQ-012 err_count  output  16  mismatch count of the current or last run, saturating at 16'hFFFF.

Function
REQ-013 The run SHALL cover all 2^(2*WIDTH) operand pairs, with {A,B} = vector counter and A as the upper half, counting from 0 upward.
REQ-014 FSM states: IDLE, DRIVE, WAIT, CHECK, FINISH.
REQ-015 IDLE->DRIVE on start; busy SHALL rise the cycle after start is sampled.
REQ-016 DRIVE SHALL present the vector on A/B and go to WAIT; A/B SHALL stay stable until the CHECK cycle ends.
REQ-017 WAIT SHALL last LATENCY-1 cycles (0 cycles when LATENCY=1) and then go to CHECK.
REQ-018 CHECK SHALL compare flag against the expected code computed internally from A and B as unsigned values; any difference, including 2'b11, counts as one mismatch.
REQ-019 CHECK SHALL go to DRIVE with counter+1, or to FINISH when the counter is all-ones; the counter SHALL NOT wrap inside a run.
REQ-020 FINISH SHALL pulse done, update pass, drop busy, and return to IDLE the next cycle.
REQ-021 Each vector SHALL take exactly LATENCY+1 cycles; with defaults, a full run is 512 cycles from DRIVE entry to FINISH.
REQ-022 start asserted while busy SHALL be ignored.
REQ-023 err_count SHALL clear on accepted start and saturate without wrapping.

Reset
REQ-024 rst SHALL force IDLE and set A=0, B=0, busy=0, done=0, pass=0, err_count=0, counter=0.
REQ-025 rst during a run SHALL abort it without pulsing done; rst SHALL take priority over start in the same cycle.

Configuration
REQ-026 Macro SELFTEST_STOP_ON_FAIL_EN, when defined: the first mismatch SHALL go from CHECK directly to FINISH (err_count=1, pass=0), and A/B SHALL hold the failing vector until the next start or rst.
REQ-027 When SELFTEST_STOP_ON_FAIL_EN is not defined, every run SHALL cover all vectors, and A/B SHALL return to 0 in FINISH.

Structure
REQ-028 The flag codes (FLAG_EQ, FLAG_LT, FLAG_GT, FLAG_BAD) and the state encoding SHALL be defined in a shared package, comparator_pkg, also used by the comparator.
REQ-029 Expected-flag generation SHALL be a sub-module, comparator_ref (WIDTH, A, B -> flag).

Verification
REQ-030 Correct comparator model, defaults, start pulse -> done after 512 cycles, pass=1, err_count=0.
REQ-031 Model stuck at flag=2'b00 -> err_count=240 and pass=0 (SELFTEST_STOP_ON_FAIL_EN undefined).
REQ-032 Same stuck model with SELFTEST_STOP_ON_FAIL_EN defined -> done at the first CHECK with A=0, B=1, err_count=1.
REQ-033 LATENCY=3 with a model registered 3 deep -> pass=1, done after 1024 cycles.
REQ-034 rst asserted at cycle 100 of a run -> all outputs reset next cycle, no done; a new start runs cleanly to pass=1.
REQ-035 start pulsed again at cycle 50 of a run -> ignored, and done occurs at the original 512-cycle point.
